// File: rtl/regfile_alu_pipe.sv
// Two-stage register-file + ALU pipeline with valid/ready handshakes.
// S1 holds captured operands; S2 is the result/flag register and write-back point.
module regfile_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               OpCode,
    input  logic [$clog2(NREGS)-1:0] RdestRegLoc,
    input  logic [$clog2(NREGS)-1:0] RsrcRegLoc,
    input  logic [WIDTH-1:0]         Imm,
    input  logic                     Imm_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         RdestOut,
    output logic [4:0]               Flags
);

    localparam int AW = $clog2(NREGS);
    localparam int M  = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_CMP  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_LSH  = 4'd7,
        OP_RSH  = 4'd8,
        OP_ARSH = 4'd9,
        OP_MOV  = 4'd10
    } op_e;

    typedef struct packed {
        logic             valid;
        op_e              op;
        logic [AW-1:0]    dst;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    s1_t              s1_q, s1_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] rdest_q, rdest_d;
    logic [4:0]       flags_q, flags_d;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res, alu_out;
    logic [4:0]       alu_flags;
    logic             c, f, l, defined, writes;
    logic             s1_move, accept, wr_en, fwd_a, fwd_b;
    logic [WIDTH-1:0] opa, opb;

    always_comb begin
        sum     = {1'b0, s1_q.a} + {1'b0, s1_q.b};
        diff    = {1'b0, s1_q.a} - {1'b0, s1_q.b};
        alu_res = '0;
        c       = 1'b0;
        f       = 1'b0;
        l       = 1'b0;
        defined = 1'b1;
        writes  = 1'b1;
        unique case (s1_q.op)
            OP_ADD: begin
                alu_res = sum[M:0];
                c       = sum[WIDTH];
                f       = (s1_q.a[M] == s1_q.b[M]) && (alu_res[M] != s1_q.a[M]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[M:0];
                c       = diff[WIDTH];
                f       = (s1_q.a[M] != s1_q.b[M]) && (alu_res[M] != s1_q.a[M]);
                l       = alu_res[M] ^ f;
                writes  = (s1_q.op == OP_SUB);
            end
            OP_AND:  alu_res = s1_q.a & s1_q.b;
            OP_OR:   alu_res = s1_q.a | s1_q.b;
            OP_XOR:  alu_res = s1_q.a ^ s1_q.b;
            OP_NOT:  alu_res = ~s1_q.a;
            OP_LSH: begin
                alu_res = {s1_q.a[M-1:0], 1'b0};
                c       = s1_q.a[M];
            end
            OP_RSH: begin
                alu_res = {1'b0, s1_q.a[M:1]};
                c       = s1_q.a[0];
            end
            OP_ARSH: begin
                alu_res = {s1_q.a[M], s1_q.a[M:1]};
                c       = s1_q.a[0];
            end
            OP_MOV:  alu_res = s1_q.b;
            default: begin
                defined = 1'b0;
                writes  = 1'b0;
            end
        endcase
        alu_flags = defined ? {alu_res[M], alu_res == '0, f, l, c} : flags_q;
        alu_out   = (s1_q.op == OP_CMP || !defined) ? s1_q.a : alu_res;
    end

    // S1 advances whenever S2 is empty or draining this edge
    assign s1_move  = s1_q.valid && (!out_valid_q || out_ready);
    assign in_ready = !(s1_q.valid && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign wr_en    = s1_move && writes;

    assign fwd_a = wr_en && (s1_q.dst == RdestRegLoc);
    assign fwd_b = wr_en && (s1_q.dst == RsrcRegLoc);
    assign opa   = fwd_a ? alu_res : regs_q[RdestRegLoc];
    assign opb   = Imm_s ? Imm : (fwd_b ? alu_res : regs_q[RsrcRegLoc]);

    always_comb begin
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        rdest_d     = rdest_q;
        flags_d     = flags_q;
        if (accept) begin
            s1_d.valid = 1'b1;
            s1_d.op    = op_e'(OpCode);
            s1_d.dst   = RdestRegLoc;
            s1_d.a     = opa;
            s1_d.b     = opb;
        end else if (s1_move) begin
            s1_d.valid = 1'b0;
        end
        if (s1_move) begin
            out_valid_d = 1'b1;
            rdest_d     = alu_out;
            flags_d     = alu_flags;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            rdest_q     <= '0;
            flags_q     <= '0;
        end else begin
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            rdest_q     <= rdest_d;
            flags_q     <= flags_d;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[s1_q.dst] <= alu_res;
        end
    end

    assign out_valid = out_valid_q;
    assign RdestOut  = rdest_q;
    assign Flags     = flags_q;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Bench for regfile_alu_pipe: directed vectors, backpressure, reset
// and randomized traffic against a sequential architectural model.
module tb_regfile_alu_pipe;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  OpCode = '0;
    logic [3:0]  RdestRegLoc = '0;
    logic [3:0]  RsrcRegLoc = '0;
    logic [15:0] Imm = '0;
    logic        Imm_s = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] RdestOut;
    logic [4:0]  Flags;

    regfile_alu_pipe #(.WIDTH(16), .NREGS(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .OpCode(OpCode), .RdestRegLoc(RdestRegLoc),
        .RsrcRegLoc(RsrcRegLoc), .Imm(Imm), .Imm_s(Imm_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .RdestOut(RdestOut), .Flags(Flags)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  d;
        logic [3:0]  s;
        logic [15:0] imm;
        logic        imm_s;
    } instr_t;

    typedef struct {
        logic [15:0] r;
        logic [4:0]  f;
    } exp_t;

    typedef struct {
        instr_t in;
        exp_t   e;
    } vec_t;

    int          npass = 0;
    int          ntotal = 0;
    logic [15:0] mregs [16];
    logic [4:0]  mflags;
    exp_t        expq [$];
    bit          hold_pend = 0;
    logic [15:0] hold_r;
    logic [4:0]  hold_f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] sx(input int v);
        return 16'(v);
    endfunction

    // Architectural model: instructions take effect one at a time in order.
    function automatic exp_t mexec(input instr_t i);
        int unsigned a, b, full;
        int          sa, sb, sr;
        logic [15:0] res;
        bit          c, f, l, def;
        exp_t        e;
        a = mregs[i.d];
        b = i.imm_s ? i.imm : mregs[i.s];
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        c = 0; f = 0; l = 0; def = 1; res = '0;
        case (i.op)
            4'd0: begin
                full = a + b; res = sx(int'(full));
                c = full > 65535; sr = sa + sb;
                f = sr > 32767 || sr < -32768;
            end
            4'd1, 4'd2: begin
                res = sx(int'(a - b)); c = a < b; sr = sa - sb;
                f = sr > 32767 || sr < -32768; l = sa < sb;
            end
            4'd3: res = sx(int'(a & b));
            4'd4: res = sx(int'(a | b));
            4'd5: res = sx(int'(a ^ b));
            4'd6: res = sx(int'(65535 - a));
            4'd7: begin res = sx(int'(a * 2)); c = a >= 32768; end
            4'd8: begin res = sx(int'(a / 2)); c = (a % 2) == 1; end
            4'd9: begin res = sx(sa >>> 1); c = (a % 2) == 1; end
            4'd10: res = sx(int'(b));
            default: def = 0;
        endcase
        if (def) mflags = {res >= 16'h8000, res == 0, f, l, c};
        e.r = (i.op == 4'd2 || !def) ? sx(int'(a)) : res;
        e.f = mflags;
        if (def && i.op != 4'd2) mregs[i.d] = res;
        return e;
    endfunction

    function automatic instr_t mk(input int op, input int d, input int s, input int imm, input bit ims);
        instr_t i;
        i.op = 4'(op); i.d = 4'(d); i.s = 4'(s); i.imm = 16'(imm); i.imm_s = ims;
        return i;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) mregs[k] = '0;
        mflags = '0;
        expq.delete();
        hold_pend = 0;
    endtask

    task automatic do_reset();
        Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge Clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rdest", RdestOut, 0);
        chk("rst_flags", Flags, 0);
        Rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);
        model_reset();
    endtask

    task automatic cycle(input bit v, input instr_t ins, input bit ordy,
                         input bit use_tab, input exp_t te, output bit acc);
        exp_t e, me;
        in_valid = v; OpCode = ins.op; RdestRegLoc = ins.d;
        RsrcRegLoc = ins.s; Imm = ins.imm; Imm_s = ins.imm_s;
        out_ready = ordy;
        #2;
        if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_rdest", RdestOut, hold_r);
            chk("hold_flags", Flags, hold_f);
        end
        hold_pend = out_valid && !ordy;
        hold_r = RdestOut; hold_f = Flags;
        if (out_valid && ordy) begin
            chk("out_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rdest", RdestOut, e.r);
                chk("flags", Flags, e.f);
            end
        end
        acc = v && in_ready;
        if (acc) begin
            me = mexec(ins);
            expq.push_back(use_tab ? te : me);
        end
        @(posedge Clk); #1;
    endtask

    task automatic drain();
        bit   acc;
        exp_t e0;
        e0.r = '0; e0.f = '0;
        for (int k = 0; k < 12 && expq.size() > 0; k++)
            cycle(0, mk(0, 0, 0, 0, 0), 1, 0, e0, acc);
        cycle(0, mk(0, 0, 0, 0, 0), 1, 0, e0, acc);
        chk("drain_empty", expq.size(), 0);
        chk("drain_idle", out_valid, 0);
    endtask

    initial begin
        vec_t   tab [$];
        vec_t   v;
        exp_t   e0;
        instr_t ins;
        bit     acc, vld, pend;
        e0.r = '0; e0.f = '0;

        // directed table: instruction, expected RdestOut, expected Flags {N,Z,F,L,C}
        v.in = mk(0, 0, 0, 1, 1);       v.e = '{16'h0001, 5'b00000}; tab.push_back(v);
        v.in = mk(10, 1, 0, 1, 1);      v.e = '{16'h0001, 5'b00000}; tab.push_back(v);
        v.in = mk(0, 1, 1, 0, 0);       v.e = '{16'h0002, 5'b00000}; tab.push_back(v);
        v.in = mk(0, 1, 1, 0, 0);       v.e = '{16'h0004, 5'b00000}; tab.push_back(v);
        v.in = mk(10, 2, 0, 5, 1);      v.e = '{16'h0005, 5'b00000}; tab.push_back(v);
        v.in = mk(1, 2, 0, 6, 1);       v.e = '{16'hFFFF, 5'b10011}; tab.push_back(v);
        v.in = mk(10, 3, 0, 'h7FFF, 1); v.e = '{16'h7FFF, 5'b00000}; tab.push_back(v);
        v.in = mk(0, 3, 0, 1, 1);       v.e = '{16'h8000, 5'b10100}; tab.push_back(v);
        v.in = mk(2, 3, 3, 0, 0);       v.e = '{16'h8000, 5'b01000}; tab.push_back(v);
        v.in = mk(10, 4, 3, 0, 0);      v.e = '{16'h8000, 5'b10000}; tab.push_back(v);
        v.in = mk(9, 4, 0, 0, 0);       v.e = '{16'hC000, 5'b10000}; tab.push_back(v);
        v.in = mk(8, 4, 0, 0, 0);       v.e = '{16'h6000, 5'b00000}; tab.push_back(v);
        v.in = mk(5, 4, 0, 'h6000, 1);  v.e = '{16'h0000, 5'b01000}; tab.push_back(v);
        v.in = mk(12, 2, 0, 0, 0);      v.e = '{16'hFFFF, 5'b01000}; tab.push_back(v);
        v.in = mk(10, 5, 2, 0, 0);      v.e = '{16'hFFFF, 5'b10000}; tab.push_back(v);
        v.in = mk(6, 5, 0, 0, 0);       v.e = '{16'h0000, 5'b01000}; tab.push_back(v);
        v.in = mk(4, 5, 0, 'h00F0, 1);  v.e = '{16'h00F0, 5'b00000}; tab.push_back(v);
        v.in = mk(3, 5, 0, 'h0030, 1);  v.e = '{16'h0030, 5'b00000}; tab.push_back(v);
        for (int k = 1; k <= 16; k++) begin
            v.in = mk(7, 0, 0, 0, 0);
            if (k < 15)       v.e = '{16'(1 << k), 5'b00000};
            else if (k == 15) v.e = '{16'h8000, 5'b10000};
            else              v.e = '{16'h0000, 5'b01001};
            tab.push_back(v);
        end

        do_reset();

        // first-result latency: accept edge, then result edge
        in_valid = 1; OpCode = 0; RdestRegLoc = 0; Imm = 1; Imm_s = 1; out_ready = 1;
        @(posedge Clk); #1;
        in_valid = 0;
        chk("lat_edge1_valid", out_valid, 0);
        @(posedge Clk); #1;
        chk("lat_edge2_valid", out_valid, 1);
        chk("lat_rdest", RdestOut, 1);
        chk("lat_flags", Flags, 0);
        @(posedge Clk); #1;
        chk("lat_consumed", out_valid, 0);

        // table streamed back-to-back
        do_reset();
        foreach (tab[i]) begin
            cycle(1, tab[i].in, 1, 1, tab[i].e, acc);
            chk("tab_accept", acc, 1);
        end
        drain();

        // backpressure: three offers with out_ready low
        do_reset();
        cycle(1, mk(10, 6, 0, 10, 1), 0, 0, e0, acc); chk("bp_acc1", acc, 1);
        cycle(1, mk(0, 6, 0, 1, 1), 0, 0, e0, acc);   chk("bp_acc2", acc, 1);
        cycle(1, mk(0, 6, 0, 2, 1), 0, 0, e0, acc);   chk("bp_stall", acc, 0);
        cycle(1, mk(0, 6, 0, 2, 1), 1, 0, e0, acc);   chk("bp_acc3", acc, 1);
        cycle(1, mk(10, 7, 6, 0, 0), 1, 0, e0, acc);  chk("bp_acc4", acc, 1);
        chk("bp_model_r6", mregs[6], 16'd13);
        drain();

        // randomized traffic with random stalls on both sides
        do_reset();
        pend = 0;
        ins = mk(0, 0, 0, 0, 0);
        for (int n = 0; n < 800; n++) begin
            if (!pend)
                ins = mk($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 3),
                         (($urandom_range(0, 3) == 0) ? 'h7FFF + $urandom_range(0, 2)
                                                      : $urandom_range(0, 65535)),
                         $urandom_range(0, 1));
            vld = pend || ($urandom_range(0, 9) < 7);
            cycle(vld, ins, $urandom_range(0, 9) < 7, 0, e0, acc);
            pend = vld && !acc;
        end
        drain();

        // reset mid-flight with one result in S2 and one instruction in S1
        do_reset();
        cycle(1, mk(10, 1, 0, 'h55, 1), 0, 0, e0, acc);
        cycle(1, mk(10, 2, 0, 'h66, 1), 0, 0, e0, acc);
        #2 Rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_rdest", RdestOut, 0);
        chk("midrst_flags", Flags, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_reset();
        cycle(1, mk(10, 8, 1, 0, 0), 1, 0, e0, acc);
        cycle(1, mk(10, 9, 2, 0, 0), 1, 0, e0, acc);
        cycle(1, mk(0, 10, 1, 0, 0), 1, 0, e0, acc);
        drain();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_alu_pipe.md
REGFILE_ALU_PIPE -- requirements
Module: regfile_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath and register width (8..32).
REQ-002 SHALL have parameter NREGS, default 16, meaning register count (power of 2, 2..32); AW = log2(NREGS).
REQ-003 SHALL have port Clk  input  1  rising-edge clock.
REQ-004 SHALL have port Rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  instruction offered.
REQ-006 SHALL have port in_ready  output  1  instruction accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port OpCode  input  4  ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, NOT=6, LSH=7, RSH=8, ARSH=9, MOV=10.
REQ-008 SHALL have port RdestRegLoc  input  AW  destination register, also operand A.
REQ-009 SHALL have port RsrcRegLoc  input  AW  source register, operand B when Imm_s=0.
REQ-010 SHALL have port Imm  input  WIDTH  immediate, operand B when Imm_s=1.
REQ-011 SHALL have port Imm_s  input  1  operand-B select.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-014 SHALL have port RdestOut  output  WIDTH  registered result.
REQ-015 SHALL have port Flags  output  5  registered {N, Z, F, L, C}.

Function
REQ-016 SHALL implement a two-stage pipeline: S1 (operand read, accept edge) and S2 (ALU execute, result/flag register and register write-back, next edge); accept-to-out_valid latency = 2 edges.
REQ-017 SHALL sustain one instruction per cycle when out_ready=1.
REQ-018 SHALL drive in_ready = !(S1 valid && out_valid && !out_ready); no instruction lost or duplicated under backpressure.
REQ-019 SHALL hold RdestOut, Flags, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL write the register file exactly once per instruction, on the edge the instruction enters S2, except CMP and undefined opcodes (no write).
REQ-021 SHALL forward the S1 ALU result to operand A and/or B when an accepted instruction reads the register S1 will write; S2 contents are already architectural.
REQ-022 SHALL compute: ADD A+B; SUB/CMP A-B; AND/OR/XOR bitwise; NOT ~A; LSH A<<1; RSH A>>1 logical; ARSH A>>>1 sign-fill; MOV B; all results truncated to WIDTH.
REQ-023 SHALL set C = carry-out (ADD), borrow i.e. A<B unsigned (SUB/CMP), shifted-out bit (shifts), 0 otherwise.
REQ-024 SHALL set F = two's-complement overflow for ADD/SUB/CMP, 0 otherwise; L = A<B signed for SUB/CMP, 0 otherwise.
REQ-025 SHALL set Z = (ALU value == 0) and N = ALU value MSB for every defined opcode; CMP output RdestOut = A.
REQ-026 SHALL, for undefined opcodes 11..15, output RdestOut = A, leave Flags unchanged, not write.
REQ-027 SHALL handle RdestRegLoc == RsrcRegLoc with A = B = same (forwarded) value.

Reset
REQ-028 SHALL on Rst=1 immediately clear all NREGS registers, S1 valid, out_valid, RdestOut and Flags to 0; in_ready = 1 after release.
REQ-029 SHALL discard in-flight S1/S2 instructions on reset with no register write.

Verification
REQ-030 Reset; ADD r0, Imm=1, Imm_s=1 -> out_valid 2 edges later, RdestOut=1, Flags=00000.
REQ-031 Back-to-back: MOV r1,#1; ADD r1,r1; ADD r1,r1 on consecutive cycles -> RdestOut 1,2,4 on consecutive cycles (forwarding).
REQ-032 MOV r2,#5; SUB r2,#6 (WIDTH=16) -> RdestOut=0xFFFF, N=1, Z=0, C=1, L=1, F=0; MOV r3,#0x7FFF; ADD r3,#1 -> 0x8000, F=1.
REQ-033 out_ready=0 for 3 cycles with 3 instructions offered -> in_ready low after 2 accepted, RdestOut held, all results later delivered in order, each register written once.
REQ-034 CMP r3,r3 -> Z=1, RdestOut=r3 value, r3 unchanged; LSH r0 fifteen times from 1 -> 0x8000, then 0 with C=1, Z=1.
REQ-035 Rst pulsed mid-flight with two instructions pending -> out_valid=0 immediately, all registers 0, no late write-back.
